video_mnist_cnn_frame_ctrl: RTL and testbench

Frame scheduler placed in front of the MNIST CNN core. It admits exactly one video frame at a time into the core. It discards input while the core drains, and counts lines at the core output to detect frame completion. It also provides enable, one-shot and frame-skip control, and reports status and counters to the register block.

---
 rtl/video_mnist_cnn_frame_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_video_mnist_cnn_frame_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_mnist_cnn_frame_ctrl.sv
// Frame scheduler in front of the MNIST CNN core: admits one frame at a time, drops input while draining.
// Optional drain watchdog: define VIDEO_MNIST_CNN_FRAME_CTRL_TIMEOUT_EN.
module video_mnist_cnn_frame_ctrl #(
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned TDATA_WIDTH   = 1,
  parameter int unsigned IMG_Y_WIDTH   = 10,
  parameter int unsigned SKIP_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned TIMEOUT_WIDTH = 24
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   ctl_enable,
  input  logic                   ctl_oneshot,
  input  logic [IMG_Y_WIDTH-1:0] param_in_height,
  input  logic [IMG_Y_WIDTH-1:0] param_out_height,
  input  logic [SKIP_WIDTH-1:0]  param_skip,
  input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
  input  logic                   s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                   s_axi4s_tvalid,
  output logic                   s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0] m_axi4s_tuser,
  output logic                   m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                   m_axi4s_tvalid,
  input  logic                   m_axi4s_tready,
  input  logic                   mon_tlast,
  input  logic                   mon_tvalid,
  input  logic                   mon_tready,
  output logic                   stat_busy,
  output logic [2:0]             stat_state,
  output logic [CNT_WIDTH-1:0]   stat_frame_cnt,
  output logic [CNT_WIDTH-1:0]   stat_drop_cnt,
  output logic [CNT_WIDTH-1:0]   stat_err_cnt,
  output logic                   irq_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SOF = 3'd1,
    PASS     = 3'd2,
    DRAIN    = 3'd3,
    SKIP     = 3'd4
  } state_t;

  typedef logic [TIMEOUT_WIDTH-1:0] tmo_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [SKIP_WIDTH-1:0] SKIP_ONE = 1;

  state_t                 state, state_n;
  logic                   once, once_n;
  logic                   seen, seen_n;
  logic [IMG_Y_WIDTH-1:0] in_line, in_line_n;
  logic [IMG_Y_WIDTH-1:0] out_line, out_line_n;
  logic [IMG_Y_WIDTH-1:0] in_h_r, in_h_n;
  logic [IMG_Y_WIDTH-1:0] out_h_r, out_h_n;
  logic [SKIP_WIDTH-1:0]  skip_r, skip_n;
  logic [SKIP_WIDTH-1:0]  skip_cnt, skip_cnt_n;
  logic [CNT_WIDTH-1:0]   frame_cnt_n, drop_cnt_n, err_cnt_n;
  logic                   irq_n;
`ifdef VIDEO_MNIST_CNN_FRAME_CTRL_TIMEOUT_EN
  tmo_t                   tmo_cnt, tmo_cnt_n;
`endif

  logic                   sof, fwd_en, s_hs, mon_hs;
  logic [IMG_Y_WIDTH-1:0] y_last, y_mon, line_nxt, out_acc;
  logic [SKIP_WIDTH-1:0]  skip_sel;
  logic                   enter_drain, frame_done, tmo_hit, err_inc, drop_inc;

  assign sof    = s_axi4s_tuser[0];
  // WAIT_SOF forwards only the SOF beat; everything before it is swallowed.
  assign fwd_en = (state == PASS) || ((state == WAIT_SOF) && (ctl_enable || once) && sof);

  assign m_axi4s_tdata  = s_axi4s_tdata;
  assign m_axi4s_tuser  = s_axi4s_tuser;
  assign m_axi4s_tlast  = s_axi4s_tlast;
  assign m_axi4s_tvalid = s_axi4s_tvalid && fwd_en;
  assign s_axi4s_tready = fwd_en ? m_axi4s_tready : 1'b1;

  assign s_hs   = s_axi4s_tvalid && s_axi4s_tready;
  assign mon_hs = mon_tvalid && mon_tready && mon_tlast;
  assign y_last = IMG_Y_WIDTH'(s_axi4s_tlast);
  assign y_mon  = IMG_Y_WIDTH'(mon_hs);

  assign stat_busy  = (state != IDLE);
  assign stat_state = state;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      once           <= 1'b0;
      seen           <= 1'b0;
      in_line        <= '0;
      out_line       <= '0;
      in_h_r         <= '0;
      out_h_r        <= '0;
      skip_r         <= '0;
      skip_cnt       <= '0;
      stat_frame_cnt <= '0;
      stat_drop_cnt  <= '0;
      stat_err_cnt   <= '0;
      irq_done       <= 1'b0;
`ifdef VIDEO_MNIST_CNN_FRAME_CTRL_TIMEOUT_EN
      tmo_cnt        <= '0;
`endif
    end else begin
      state          <= state_n;
      once           <= once_n;
      seen           <= seen_n;
      in_line        <= in_line_n;
      out_line       <= out_line_n;
      in_h_r         <= in_h_n;
      out_h_r        <= out_h_n;
      skip_r         <= skip_n;
      skip_cnt       <= skip_cnt_n;
      stat_frame_cnt <= frame_cnt_n;
      stat_drop_cnt  <= drop_cnt_n;
      stat_err_cnt   <= err_cnt_n;
      irq_done       <= irq_n;
`ifdef VIDEO_MNIST_CNN_FRAME_CTRL_TIMEOUT_EN
      tmo_cnt        <= tmo_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    once_n      = once;
    seen_n      = seen;
    in_line_n   = in_line;
    out_line_n  = out_line;
    in_h_n      = in_h_r;
    out_h_n     = out_h_r;
    skip_n      = skip_r;
    skip_cnt_n  = skip_cnt;
    frame_cnt_n = stat_frame_cnt;
    drop_cnt_n  = stat_drop_cnt;
    err_cnt_n   = stat_err_cnt;
    irq_n       = 1'b0;
    line_nxt    = '0;
    out_acc     = out_line + y_mon;
    skip_sel    = skip_r;
    enter_drain = 1'b0;
    frame_done  = 1'b0;
    tmo_hit     = 1'b0;
    err_inc     = 1'b0;
    drop_inc    = 1'b0;
`ifdef VIDEO_MNIST_CNN_FRAME_CTRL_TIMEOUT_EN
    tmo_cnt_n   = tmo_cnt;
`endif

    case (state)
      IDLE: begin
        if (ctl_enable || ctl_oneshot) begin
          state_n = WAIT_SOF;
          once_n  = ctl_oneshot;
        end
      end
      WAIT_SOF: begin
        if (!(ctl_enable || once)) begin
          state_n = IDLE;
        end else if (s_hs && sof) begin
          in_h_n     = param_in_height;
          seen_n     = 1'b0;
          out_acc    = y_mon;
          out_line_n = out_acc;
          line_nxt   = y_last;
          in_line_n  = line_nxt;
          if (line_nxt == param_in_height) enter_drain = 1'b1;
          else state_n = PASS;
        end
      end
      PASS: begin
        out_line_n = out_acc;
        if (s_hs) begin
          seen_n = !sof;
          if (sof && ((in_line != '0) || seen)) begin
            err_inc  = 1'b1;
            line_nxt = y_last;
          end else begin
            line_nxt = in_line + y_last;
          end
          in_line_n = line_nxt;
          if (line_nxt == in_h_r) enter_drain = 1'b1;
        end
      end
      DRAIN: begin
        out_line_n = out_acc;
        if (s_axi4s_tvalid && sof) drop_inc = 1'b1;
        if (out_acc >= out_h_r) frame_done = 1'b1;
`ifdef VIDEO_MNIST_CNN_FRAME_CTRL_TIMEOUT_EN
        else if (mon_hs) tmo_cnt_n = '0;
        else if (tmo_cnt == '1) tmo_hit = 1'b1;
        else tmo_cnt_n = tmo_cnt + tmo_t'(1);
`endif
      end
      SKIP: begin
        if (s_axi4s_tvalid && sof) begin
          drop_inc   = 1'b1;
          skip_cnt_n = skip_cnt + SKIP_ONE;
        end
        if (!ctl_enable) begin
          state_n = IDLE;
          once_n  = 1'b0;
        end else if (s_axi4s_tvalid && sof && (skip_cnt_n == skip_r)) begin
          state_n = WAIT_SOF;
        end
      end
      default: state_n = IDLE;
    endcase

    // Frame params latch at drain entry; a completion in that same cycle goes straight to the drain exit.
    if (enter_drain) begin
      out_h_n  = param_out_height;
      skip_n   = param_skip;
      skip_sel = param_skip;
`ifdef VIDEO_MNIST_CNN_FRAME_CTRL_TIMEOUT_EN
      tmo_cnt_n = '0;
`endif
      if (out_acc >= param_out_height) frame_done = 1'b1;
      else state_n = DRAIN;
    end

    if (frame_done || tmo_hit) begin
      irq_n = 1'b1;
      if (skip_sel != '0) begin
        state_n    = SKIP;
        skip_cnt_n = '0;
      end else if (once || !ctl_enable) begin
        state_n = IDLE;
        once_n  = 1'b0;
      end else begin
        state_n = WAIT_SOF;
      end
    end

    if (frame_done)          frame_cnt_n = stat_frame_cnt + CNT_ONE;
    if (err_inc || tmo_hit)  err_cnt_n   = stat_err_cnt + CNT_ONE;
    if (drop_inc)            drop_cnt_n  = stat_drop_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_video_mnist_cnn_frame_ctrl.sv
// Directed bench for video_mnist_cnn_frame_ctrl: forwarded beats are scoreboarded, status checked by value.
module tb_video_mnist_cnn_frame_ctrl;

  localparam int unsigned TW = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          ctl_enable, ctl_oneshot;
  logic [9:0]    param_in_height, param_out_height;
  logic [7:0]    param_skip;
  logic [0:0]    s_tuser, m_tuser;
  logic          s_tlast, s_tvalid, s_tready;
  logic [TW-1:0] s_tdata, m_tdata;
  logic          m_tlast, m_tvalid, m_tready;
  logic          mon_tlast, mon_tvalid, mon_tready;
  logic          stat_busy;
  logic [2:0]    stat_state;
  logic [15:0]   stat_frame_cnt, stat_drop_cnt, stat_err_cnt;
  logic          irq_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int irq_seen  = 0;
  logic [TW+1:0] exp_q[$];

  always #5 aclk = ~aclk;

  video_mnist_cnn_frame_ctrl #(.TDATA_WIDTH(TW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .ctl_enable(ctl_enable), .ctl_oneshot(ctl_oneshot),
    .param_in_height(param_in_height), .param_out_height(param_out_height), .param_skip(param_skip),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
    .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
    .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tdata(m_tdata),
    .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready),
    .mon_tlast(mon_tlast), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .stat_busy(stat_busy), .stat_state(stat_state),
    .stat_frame_cnt(stat_frame_cnt), .stat_drop_cnt(stat_drop_cnt), .stat_err_cnt(stat_err_cnt),
    .irq_done(irq_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output-side scoreboard: every forwarded beat must match the head of the queue.
  always @(negedge aclk) begin
    logic [TW+1:0] got, exp;
    logic          have;
    if (aresetn) begin
      if (irq_done) irq_seen++;
      if (m_tvalid && m_tready) begin
        got  = {m_tuser, m_tlast, m_tdata};
        have = (exp_q.size() != 0);
        exp  = '0;
        if (have) exp = exp_q.pop_front();
        total_cnt++;
        assert (have && got === exp) pass_cnt++;
        else begin
          fail_cnt++;
          $error("FAIL fwd_beat: got %h expected %h (queued=%0d)", got, exp, have);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic beat(input logic sof, input logic last, input logic fwd);
    logic [TW-1:0] d;
    d        = TW'($urandom_range(255));
    s_tvalid = 1'b1;
    s_tuser  = sof;
    s_tlast  = last;
    s_tdata  = d;
    if (fwd) exp_q.push_back({sof, last, d});
    tick(1);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic frame(input int lines, input logic fwd);
    for (int l = 0; l < lines; l++) begin
      beat(l == 0, 1'b0, fwd);
      beat(1'b0, 1'b1, fwd);
    end
  endtask

  task automatic mon_line();
    mon_tvalid = 1'b1;
    mon_tlast  = 1'b1;
    tick(1);
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; ctl_enable = 1'b0; ctl_oneshot = 1'b0;
    param_in_height = 10'd4; param_out_height = 10'd1; param_skip = 8'd0;
    s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tvalid = 1'b0;
    m_tready = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0; mon_tvalid = 1'b0;

    tick(2);
    check("rst_state", 32'(stat_state), 0);
    check("rst_busy", 32'(stat_busy), 0);
    check("rst_cnts", 32'({stat_frame_cnt, stat_drop_cnt} | 32'(stat_err_cnt)), 0);
    check("rst_irq", 32'(irq_done), 0);
    check("rst_mvalid", 32'(m_tvalid), 0);
    check("rst_sready", 32'(s_tready), 1);

    // Two back-to-back frames in continuous mode
    aresetn = 1'b1; ctl_enable = 1'b1;
    tick(1);
    check("enable_wait_sof", 32'(stat_state), 1);
    frame(4, 1'b1);
    check("drain_after_frame", 32'(stat_state), 3);
    mon_line();
    check("irq_pulse", 32'(irq_done), 1);
    tick(1);
    check("irq_one_cycle", 32'(irq_done), 0);
    check("back_to_wait", 32'(stat_state), 1);
    frame(4, 1'b1);
    mon_line();
    tick(1);
    check("frame_cnt_2", 32'(stat_frame_cnt), 2);

    // Non-SOF beats in WAIT_SOF are swallowed
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    check("still_wait_sof", 32'(stat_state), 1);
    frame(4, 1'b1);
    mon_line();
    tick(1);
    check("frame_cnt_3", 32'(stat_frame_cnt), 3);

    // Skip two frames after each processed one
    param_skip = 8'd2;
    frame(4, 1'b1);
    mon_line();
    tick(1);
    check("enter_skip", 32'(stat_state), 4);
    frame(4, 1'b0);
    frame(4, 1'b0);
    check("skip_done", 32'(stat_state), 1);
    frame(4, 1'b1);
    mon_line();
    tick(1);
    frame(4, 1'b0);
    check("skip_drop_cnt", 32'(stat_drop_cnt), 3);
    check("skip_frame_cnt", 32'(stat_frame_cnt), 5);
    check("skip_state", 32'(stat_state), 4);

    // One-shot with enable low
    param_skip = 8'd0; ctl_enable = 1'b0;
    tick(1);
    check("skip_disable_idle", 32'(stat_state), 0);
    ctl_oneshot = 1'b1;
    tick(1);
    ctl_oneshot = 1'b0;
    check("oneshot_wait", 32'(stat_state), 1);
    frame(4, 1'b1);
    mon_line();
    tick(1);
    check("oneshot_idle", 32'(stat_state), 0);
    check("oneshot_busy", 32'(stat_busy), 0);
    frame(4, 1'b0);
    frame(4, 1'b0);
    check("oneshot_frame_cnt", 32'(stat_frame_cnt), 6);
    check("idle_no_drop_cnt", 32'(stat_drop_cnt), 3);

    // Early SOF at line 2 restarts the line count
    ctl_enable = 1'b1;
    tick(1);
    beat(1'b1, 1'b0, 1'b1); beat(1'b0, 1'b1, 1'b1);
    beat(1'b0, 1'b0, 1'b1); beat(1'b0, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b1); beat(1'b0, 1'b1, 1'b1);
    check("early_sof_err", 32'(stat_err_cnt), 1);
    for (int l = 0; l < 2; l++) begin
      beat(1'b0, 1'b0, 1'b1); beat(1'b0, 1'b1, 1'b1);
    end
    check("early_sof_still_pass", 32'(stat_state), 2);
    beat(1'b0, 1'b0, 1'b1); beat(1'b0, 1'b1, 1'b1);
    check("early_sof_drain", 32'(stat_state), 3);
    mon_line();
    tick(1);
    check("early_sof_frame_cnt", 32'(stat_frame_cnt), 7);

    // Asynchronous reset in the middle of PASS
    beat(1'b1, 1'b0, 1'b1); beat(1'b0, 1'b1, 1'b1); beat(1'b0, 1'b0, 1'b1);
    check("pre_rst_pass", 32'(stat_state), 2);
    s_tvalid = 1'b1; s_tuser = 1'b0; s_tlast = 1'b0;
    aresetn  = 1'b0;
    #1;
    check("midrst_mvalid", 32'(m_tvalid), 0);
    check("midrst_sready", 32'(s_tready), 1);
    check("midrst_state", 32'(stat_state), 0);
    check("midrst_cnts", 32'({stat_frame_cnt, stat_drop_cnt} | 32'(stat_err_cnt)), 0);
    s_tvalid = 1'b0;
    tick(1);
    aresetn = 1'b1;
    tick(1);
    check("post_rst_wait", 32'(stat_state), 1);
    frame(4, 1'b1);
    mon_line();
    tick(1);
    check("post_rst_frame_cnt", 32'(stat_frame_cnt), 1);
    check("post_rst_err_cnt", 32'(stat_err_cnt), 0);

    tick(2);
    check("queue_empty", 32'(exp_q.size()), 0);
    check("irq_total", 32'(irq_seen), 8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
